vga_pixel_pipeline: RTL and testbench



---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_pixel_pipeline_palette.sv | 23 ++
 rtl/vga_pixel_pipeline.sv | 121 ++++++++++++
 tb/tb_vga_pixel_pipeline.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type and the built-in palette for the pixel pipeline.
// Timing defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_H_ACT   = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;
  localparam int VGA_V_ACT   = 480;
  localparam int VGA_V_FRONT = 10;

  localparam int H_TOTAL = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACT + VGA_H_FRONT;
  localparam int V_TOTAL = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACT + VGA_V_FRONT;
  localparam int ADDR_W  = 19;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // Entries 8..255 are black.
  function automatic rgb24_t default_palette(input logic [7:0] idx);
    rgb24_t c;
    case (idx)
      8'd1:    c = 24'h00FF00;
      8'd2:    c = 24'h0000FF;
      8'd3:    c = 24'hFF0000;
      8'd4:    c = 24'hFFFFFF;
      8'd5:    c = 24'hFFFF00;
      8'd6:    c = 24'h808080;
      8'd7:    c = 24'h00FFFF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pixel_pipeline_palette.sv
// 256x24 read-only palette with a registered read port.
// iZero forces the registered colour to black for blanked pixels.
module vga_palette_rom
  import vga_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic [7:0] iAddr,
  input  logic       iZero,
  output rgb24_t     oData
);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oData <= '0;
    end else if (iZero) begin
      oData <= '0;
    end else begin
      oData <= default_palette(iAddr);
    end
  end

endmodule

// File: rtl/vga_pixel_pipeline.sv
// VGA front end: sync/blank timing, frame-buffer address generation and palette lookup.
// RGB, HS, VS and BLANK_n leave together three clocks after the counter position they describe.
module vga_pixel_pipeline
  import vga_pkg::*;
#(
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BACK  = VGA_H_BACK,
  parameter int H_ACT   = VGA_H_ACT,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BACK  = VGA_V_BACK,
  parameter int V_ACT   = VGA_V_ACT,
  parameter int V_FRONT = VGA_V_FRONT
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  output logic [ADDR_W-1:0] oADDR,
  output logic [9:0]        oX,
  output logic [8:0]        oY,
  output logic              oDE,
  input  logic [7:0]        iIndex,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic [7:0]        oR,
  output logic [7:0]        oG,
  output logic [7:0]        oB
);

  localparam int LP_H_TOT  = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int LP_V_TOT  = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int LP_H_AST  = H_SYNC + H_BACK;
  localparam int LP_H_AEND = LP_H_AST + H_ACT;
  localparam int LP_V_AST  = V_SYNC + V_BACK;
  localparam int LP_V_AEND = LP_V_AST + V_ACT;

  logic [9:0]        r_h_cnt;
  logic [9:0]        r_v_cnt;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic              r_hs1, r_vs1;
  logic              r_de2, r_hs2, r_vs2;
  logic              w_h_last;
  logic              w_hs0, w_vs0, w_de0;
  rgb24_t            w_rgb;

  assign w_h_last = (r_h_cnt == 10'(LP_H_TOT - 1));

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == 10'(LP_V_TOT - 1)) ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  assign w_hs0 = (r_h_cnt >= 10'(H_SYNC));
  assign w_vs0 = (r_v_cnt >= 10'(V_SYNC));
  assign w_de0 = (r_h_cnt >= 10'(LP_H_AST)) && (r_h_cnt < 10'(LP_H_AEND)) &&
                 (r_v_cnt >= 10'(LP_V_AST)) && (r_v_cnt < 10'(LP_V_AEND));

  // Address is a running pixel count rather than y*H_ACT+x; it restarts every vertical sync.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_pix_cnt <= '0;
      oADDR     <= '0;
      oX        <= '0;
      oY        <= '0;
      oDE       <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
    end else begin
      oDE   <= w_de0;
      r_hs1 <= w_hs0;
      r_vs1 <= w_vs0;
      if (w_de0) begin
        oX        <= r_h_cnt - 10'(LP_H_AST);
        oY        <= 9'(r_v_cnt - 10'(LP_V_AST));
        oADDR     <= r_pix_cnt;
        r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
      end else if (!w_vs0) begin
        r_pix_cnt <= '0;
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_de2    <= 1'b0;
      r_hs2    <= 1'b1;
      r_vs2    <= 1'b1;
      oBLANK_n <= 1'b0;
      oHS      <= 1'b1;
      oVS      <= 1'b1;
    end else begin
      r_de2    <= oDE;
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
      oBLANK_n <= r_de2;
      oHS      <= r_hs2;
      oVS      <= r_vs2;
    end
  end

  // iIndex arrives one clock after oADDR and feeds the palette's registered read directly.
  vga_palette_rom u_palette (
    .iCLK   (iVGA_CLK),
    .iRST_n (iRST_n),
    .iAddr  (iIndex),
    .iZero  (!r_de2),
    .oData  (w_rgb)
  );

  assign oR = w_rgb.r;
  assign oG = w_rgb.g;
  assign oB = w_rgb.b;

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Bench for vga_pixel_pipeline with a shortened vertical timing and a model frame-buffer RAM.
// Expected outputs come from screen-position arithmetic on a cycle count since reset release.
module tb_vga_pixel_pipeline;

  localparam int HT    = 800;
  localparam int HS    = 96;
  localparam int HAS   = 144;
  localparam int HACT  = 640;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int VACT  = 6;
  localparam int VF    = 2;
  localparam int VT    = VS + VB + VACT + VF;
  localparam int VAS   = VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NPIX  = HACT * VACT;
  localparam int NFR   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  idx = 8'd0;
  logic [18:0] oADDR;
  logic [9:0]  oX;
  logic [8:0]  oY;
  logic        oDE, oHS, oVS, oBLANK_n;
  logic [7:0]  oR, oG, oB;
  logic [23:0] rgb;

  int n;
  int n_cmp = 0;
  int n_err = 0;
  bit stats_on = 1'b1;
  bit saw645 = 1'b0;

  int sched [NFR] = '{0, 0, 1, 2, 3, 4};
  logic [7:0] ram_img [NPIX];

  int hs_low [NFR], vs_low [NFR], bl_hi [NFR], red [NFR], nzrgb [NFR];
  int white [NFR], white_late [NFR];
  int first_a [NFR], last_a [NFR];
  bit seen [NFR];

  always #5 clk = ~clk;

  assign rgb = {oR, oG, oB};

  vga_pixel_pipeline #(
    .V_SYNC(VS), .V_BACK(VB), .V_ACT(VACT), .V_FRONT(VF)
  ) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .oADDR    (oADDR),
    .oX       (oX),
    .oY       (oY),
    .oDE      (oDE),
    .iIndex   (idx),
    .oHS      (oHS),
    .oVS      (oVS),
    .oBLANK_n (oBLANK_n),
    .oR       (oR),
    .oG       (oG),
    .oB       (oB)
  );

  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else        n <= n + 1;

  function automatic bit m_de(int p);
    int h = p % HT;
    int v = (p / HT) % VT;
    return (h >= HAS) && (h < HAS + HACT) && (v >= VAS) && (v < VAS + VACT);
  endfunction

  function automatic int m_mode(int p);
    int f = p / FRAME;
    return (f < NFR) ? sched[f] : 1;
  endfunction

  function automatic logic [23:0] m_pal(logic [7:0] i);
    case (i)
      8'd1: return 24'h00FF00;
      8'd2: return 24'h0000FF;
      8'd3: return 24'hFF0000;
      8'd4: return 24'hFFFFFF;
      8'd5: return 24'hFFFF00;
      8'd6: return 24'h808080;
      8'd7: return 24'h00FFFF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [7:0] m_idx(int p);
    int x = p % HT - HAS;
    int y = (p / HT) % VT - VAS;
    int a = y * HACT + x;
    case (m_mode(p))
      0: return 8'(a);
      1: return 8'd3;
      2: return 8'd200;
      3: return (x == 0) ? 8'd4 : 8'd0;
      default: return ram_img[a];
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-buffer RAM: answers the address shown this cycle on the next cycle.
  initial begin
    logic [7:0] nxt;
    nxt = 8'd0;
    forever begin
      @(negedge clk);
      if (n >= 1) begin
        case (m_mode(n - 1))
          0: nxt = oADDR[7:0];
          1: nxt = 8'd3;
          2: nxt = 8'd200;
          3: nxt = (oDE && oX == 10'd0) ? 8'd4 : 8'd0;
          default: nxt = ram_img[int'(oADDR) % NPIX];
        endcase
      end
      @(posedge clk);
      #1 idx = nxt;
    end
  end

  // Per-cycle comparison against the position model plus frame statistics.
  initial begin
    logic        ex_de, e_hs, e_vs, e_bl, prev_bl;
    logic [9:0]  ex_x;
    logic [8:0]  ex_y;
    logic [18:0] ex_a;
    logic [23:0] e_rgb;
    int p, h, v, f;
    ex_de = 0; ex_x = 0; ex_y = 0; ex_a = 0; prev_bl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || n == 0) begin
        ex_de = 0; ex_x = 0; ex_y = 0; ex_a = 0;
      end else begin
        p = n - 1;
        ex_de = m_de(p);
        if (ex_de) begin
          ex_x = 10'(p % HT - HAS);
          ex_y = 9'((p / HT) % VT - VAS);
          ex_a = 19'(int'(ex_y) * HACT + int'(ex_x));
        end
      end
      if (!rst_n || n < 3) begin
        e_hs = 1; e_vs = 1; e_bl = 0; e_rgb = 24'h0;
      end else begin
        p = n - 3;
        h = p % HT;
        v = (p / HT) % VT;
        e_hs = (h >= HS);
        e_vs = (v >= VS);
        e_bl = m_de(p);
        e_rgb = e_bl ? m_pal(m_idx(p)) : 24'h0;
      end
      n_cmp++;
      if ({oDE, oX, oY, oADDR} !== {ex_de, ex_x, ex_y, ex_a}) begin
        n_err++;
        $display("FAIL addr_stage n=%0d: got de=%0d x=%0d y=%0d a=%0d expected de=%0d x=%0d y=%0d a=%0d",
                 n, oDE, oX, oY, oADDR, ex_de, ex_x, ex_y, ex_a);
      end
      n_cmp++;
      if ({oHS, oVS, oBLANK_n, rgb} !== {e_hs, e_vs, e_bl, e_rgb}) begin
        n_err++;
        $display("FAIL video_out n=%0d: got hs=%0d vs=%0d bl=%0d rgb=%06h expected hs=%0d vs=%0d bl=%0d rgb=%06h",
                 n, oHS, oVS, oBLANK_n, rgb, e_hs, e_vs, e_bl, e_rgb);
      end
      if (stats_on && rst_n && n >= 1) begin
        f = (n - 1) / FRAME;
        if (f < NFR && oDE) begin
          if (!seen[f]) begin seen[f] = 1; first_a[f] = int'(oADDR); end
          last_a[f] = int'(oADDR);
          if (f == 0 && oX == 10'd5 && oY == 9'd1) begin
            saw645 = 1;
            chk("addr_x5_y1", oADDR, 645);
          end
        end
      end
      if (stats_on && rst_n && n >= 3) begin
        f = (n - 3) / FRAME;
        if (f < NFR) begin
          hs_low[f] += int'(!oHS);
          vs_low[f] += int'(!oVS);
          bl_hi[f]  += int'(oBLANK_n);
          red[f]    += int'(oBLANK_n && rgb == 24'hFF0000);
          nzrgb[f]  += int'(rgb != 24'h0);
          white[f]  += int'(rgb == 24'hFFFFFF);
          white_late[f] += int'(rgb == 24'hFFFFFF && prev_bl);
        end
      end
      prev_bl = oBLANK_n;
    end
  end

  initial begin
    int k;
    for (int i = 0; i < NPIX; i++) ram_img[i] = 8'($urandom_range(0, 11));
    for (int i = 0; i < NFR; i++) begin
      hs_low[i] = 0; vs_low[i] = 0; bl_hi[i] = 0; red[i] = 0; nzrgb[i] = 0;
      white[i] = 0; white_late[i] = 0; first_a[i] = -1; last_a[i] = -1; seen[i] = 0;
    end

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_hs", oHS, 1);
    chk("reset_vs", oVS, 1);
    chk("reset_blank", oBLANK_n, 0);
    chk("reset_rgb", rgb, 0);
    chk("reset_addr", oADDR, 0);
    chk("reset_de", oDE, 0);
    @(negedge clk);
    rst_n = 1'b1;

    while (n < NFR * FRAME + 3) @(negedge clk);
    stats_on = 1'b0;

    for (int f = 0; f < 2; f++) begin
      chk("hs_low_per_frame", hs_low[f], 96 * VT);
      chk("vs_low_per_frame", vs_low[f], 1600);
      chk("active_per_frame", bl_hi[f], NPIX);
      chk("first_addr", first_a[f], 0);
      chk("last_addr", last_a[f], NPIX - 1);
    end
    chk("saw_pixel_5_1", saw645, 1);
    chk("idx3_red_pixels", red[2], NPIX);
    chk("idx3_no_colour_in_blank", nzrgb[2], NPIX);
    chk("idx200_black", nzrgb[3], 0);
    chk("align_white_count", white[4], VACT);
    chk("align_white_not_first", white_late[4], 0);
    chk("align_other_colour", nzrgb[4], VACT);
    chk("random_active_count", bl_hi[5], NPIX);

    // Drop reset mid-line in an active row and expect outputs to clear before any edge.
    while (n != NFR * FRAME + (VAS + 2) * HT + 400) @(negedge clk);
    chk("pre_reset_blank", oBLANK_n, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hs", oHS, 1);
    chk("async_vs", oVS, 1);
    chk("async_blank", oBLANK_n, 0);
    chk("async_rgb", rgb, 0);
    chk("async_addr", oADDR, 0);
    chk("async_xy_de", {oX, oY, oDE}, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (!oHS) begin k = c; break; end
    end
    chk("hs_edges_after_release", k, 3);

    k = 0;
    for (int c = 0; c < (VAS + 1) * HT + 10; c++) begin
      @(negedge clk);
      if (oDE) begin k = 1; break; end
    end
    chk("de_after_release", k, 1);
    chk("restart_first_addr", oADDR, 0);
    chk("restart_first_xy", {oX, oY}, 0);

    repeat (50) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
